// File: rtl/vga_sync_monitor_if.sv
// VGA pin bundle between a sync source and the passive monitor.
interface vga_sync_monitor_if;
  logic       VGA_HS;
  logic       VGA_VS;
  logic [3:0] VGA_R;
  logic [3:0] VGA_G;
  logic [3:0] VGA_B;

  modport master (output VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
  modport slave  (input  VGA_HS, VGA_VS, VGA_R, VGA_G, VGA_B);
endinterface

// File: rtl/vga_sync_monitor.sv
// Passive VGA timing checker: measures HS/VS timing, locks onto the expected mode.
// Optional per-frame pixel checksum is built only when MON_CHECKSUM_EN is defined.
module vga_sync_monitor #(
  parameter int unsigned H_PERIOD_CLKS  = 1600,
  parameter int unsigned HS_WIDTH_CLKS  = 192,
  parameter int unsigned V_LINES        = 525,
  parameter int unsigned VS_WIDTH_LINES = 2,
  parameter int unsigned TOL            = 4,
  parameter int unsigned LOCK_FRAMES    = 2
) (
  input  logic              MAX10_CLK1_50,
  input  logic              RST,
  vga_sync_monitor_if.slave vga,
  output logic              locked,
  output logic              frame_done,
  output logic [11:0]       h_period,
  output logic [11:0]       hs_width,
  output logic [9:0]        v_lines,
  output logic [3:0]        vs_width,
  output logic [15:0]       frame_count,
  output logic              err_h,
  output logic              err_v,
  output logic [15:0]       checksum
);

  localparam logic [11:0] HpMin    = 12'(H_PERIOD_CLKS - TOL);
  localparam logic [11:0] HpMax    = 12'(H_PERIOD_CLKS + TOL);
  localparam logic [11:0] HwMin    = 12'(HS_WIDTH_CLKS - TOL);
  localparam logic [11:0] HwMax    = 12'(HS_WIDTH_CLKS + TOL);
  localparam logic [9:0]  VLines   = 10'(V_LINES);
  localparam logic [3:0]  VsWidth  = 4'(VS_WIDTH_LINES);
  localparam logic [7:0]  LockLast = 8'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e      state_q, state_d;
  logic [2:0]  hs_pipe_q, vs_pipe_q;  // {delayed, synced, meta}
  logic [11:0] h_cnt_q, h_period_q, hs_width_q;
  logic [9:0]  line_cnt_q, v_lines_q;
  logic [3:0]  vsl_cnt_q, vs_width_q;
  logic [15:0] frame_count_q;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic        h_seen_q, vs_seen_q, frame_bad_q, frame_done_q, err_h_q, err_v_q;
  logic        err_h_set, err_v_set, restart;

  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      hs_pipe_q <= 3'b111;
      vs_pipe_q <= 3'b111;
    end else begin
      hs_pipe_q <= {hs_pipe_q[1:0], vga.VGA_HS};
      vs_pipe_q <= {vs_pipe_q[1:0], vga.VGA_VS};
    end
  end

  logic hs_sync, vs_sync, hs_fall, hs_rise, vs_fall;
  assign hs_sync = hs_pipe_q[1];
  assign vs_sync = vs_pipe_q[1];
  assign hs_fall = hs_pipe_q[2] & ~hs_sync;
  assign hs_rise = ~hs_pipe_q[2] & hs_sync;
  assign vs_fall = vs_pipe_q[2] & ~vs_sync;

  logic period_ok, width_ok, period_chk, line_bad, v_ok, frame_good, frame_pulse;
  logic h_timeout, v_timeout;
  assign period_ok   = (h_cnt_q >= HpMin) && (h_cnt_q <= HpMax);
  assign width_ok    = (h_cnt_q >= HwMin) && (h_cnt_q <= HwMax);
  // The line that opens a frame is not judged; the fall closing a frame's last line is.
  assign period_chk  = hs_fall && h_seen_q && (vs_fall || line_cnt_q > 10'd1);
  assign line_bad    = (period_chk && !period_ok) || (hs_rise && h_seen_q && !width_ok);
  assign v_ok        = (line_cnt_q == VLines) && (vsl_cnt_q == VsWidth);
  assign frame_good  = !frame_bad_q && !line_bad && v_ok;
  assign frame_pulse = vs_fall && vs_seen_q;
  assign h_timeout   = (h_cnt_q == 12'd4094) && !hs_fall;
  assign v_timeout   = hs_fall && !vs_fall && (line_cnt_q == 10'h3ff);

  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) state_q <= StSearch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_h_set  = 1'b0;
    err_v_set  = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (frame_pulse) begin
          state_d    = StMeasure;
          good_cnt_d = '0;
        end
      end
      StMeasure: begin
        if (frame_pulse) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q >= LockLast) state_d = StLocked;
          end else begin
            good_cnt_d = '0;
          end
        end
      end
      StLocked: begin
        if (line_bad) begin
          state_d   = StSearch;
          err_h_set = 1'b1;
        end else if (frame_pulse && !v_ok) begin
          state_d   = StSearch;
          err_v_set = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
    if (h_timeout) begin
      state_d   = StSearch;
      err_h_set = err_h_set | (state_q == StLocked);
    end
    if (v_timeout) begin
      state_d   = StSearch;
      err_v_set = err_v_set | (state_q == StLocked);
    end
    restart = (state_d == StSearch) && ((state_q != StSearch) || h_timeout || v_timeout);
  end

  always_comb begin
    locked = (state_q == StLocked);
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      h_cnt_q       <= '0;
      h_period_q    <= '0;
      hs_width_q    <= '0;
      line_cnt_q    <= '0;
      vsl_cnt_q     <= '0;
      v_lines_q     <= '0;
      vs_width_q    <= '0;
      frame_count_q <= '0;
      good_cnt_q    <= '0;
      h_seen_q      <= 1'b0;
      vs_seen_q     <= 1'b0;
      frame_bad_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      err_h_q       <= 1'b0;
      err_v_q       <= 1'b0;
    end else begin
      if (hs_fall)                  h_cnt_q <= 12'd1;
      else if (h_cnt_q != 12'hfff)  h_cnt_q <= h_cnt_q + 12'd1;
      if (hs_fall && h_seen_q)      h_period_q <= h_cnt_q;
      if (hs_rise && h_seen_q)      hs_width_q <= h_cnt_q;
      h_seen_q <= !restart && (h_seen_q || hs_fall);

      // An HS fall coincident with the VS fall is the new frame's first line.
      if (restart) begin
        line_cnt_q <= '0;
        vsl_cnt_q  <= '0;
      end else if (vs_fall) begin
        line_cnt_q <= hs_fall ? 10'd1 : 10'd0;
        vsl_cnt_q  <= hs_fall ? 4'd1 : 4'd0;
      end else if (hs_fall) begin
        if (line_cnt_q != 10'h3ff)          line_cnt_q <= line_cnt_q + 10'd1;
        if (!vs_sync && vsl_cnt_q != 4'hf)  vsl_cnt_q  <= vsl_cnt_q + 4'd1;
      end

      vs_seen_q    <= !restart && (vs_seen_q || vs_fall);
      frame_bad_q  <= !(restart || vs_fall) && (frame_bad_q || line_bad);
      frame_done_q <= frame_pulse;
      if (frame_pulse) begin
        frame_count_q <= frame_count_q + 16'd1;
        v_lines_q     <= line_cnt_q;
        vs_width_q    <= vsl_cnt_q;
      end
      good_cnt_q <= good_cnt_d;
      err_h_q    <= err_h_q | err_h_set;
      err_v_q    <= err_v_q | err_v_set;
    end
  end

  assign frame_done  = frame_done_q;
  assign h_period    = h_period_q;
  assign hs_width    = hs_width_q;
  assign v_lines     = v_lines_q;
  assign vs_width    = vs_width_q;
  assign frame_count = frame_count_q;
  assign err_h       = err_h_q;
  assign err_v       = err_v_q;

`ifdef MON_CHECKSUM_EN
  logic [15:0] acc_q, checksum_q;
  always_ff @(posedge MAX10_CLK1_50 or posedge RST) begin
    if (RST) begin
      acc_q      <= '0;
      checksum_q <= '0;
    end else if (frame_pulse) begin
      checksum_q <= acc_q;
      acc_q      <= '0;
    end else if (hs_sync && vs_sync) begin
      acc_q <= acc_q + {4'h0, vga.VGA_R, vga.VGA_G, vga.VGA_B};
    end
  end
  assign checksum = checksum_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{vga.VGA_R, vga.VGA_G, vga.VGA_B};
  assign checksum   = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down video mode (40 clk lines, 20 lines).
module tb_vga_sync_monitor;
  localparam int H   = 40;
  localparam int HSW = 8;
  localparam int VL  = 20;
  localparam int VSW = 2;
`ifdef MON_CHECKSUM_EN
  localparam logic [15:0] CsumIdeal = 16'd576;  // 18 VS-high lines x 32 HS-high clocks
`else
  localparam logic [15:0] CsumIdeal = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        locked, frame_done, err_h, err_v;
  logic [11:0] h_period, hs_width;
  logic [9:0]  v_lines;
  logic [3:0]  vs_width;
  logic [15:0] frame_count, checksum;
  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_n  = 0;
  logic        lock_hist [0:63];

  vga_sync_monitor_if vga ();

  vga_sync_monitor #(
    .H_PERIOD_CLKS (H),
    .HS_WIDTH_CLKS (HSW),
    .V_LINES       (VL),
    .VS_WIDTH_LINES(VSW),
    .TOL           (4),
    .LOCK_FRAMES   (2)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RST          (rst),
    .vga          (vga.slave),
    .locked       (locked),
    .frame_done   (frame_done),
    .h_period     (h_period),
    .hs_width     (hs_width),
    .v_lines      (v_lines),
    .vs_width     (vs_width),
    .frame_count  (frame_count),
    .err_h        (err_h),
    .err_v        (err_v),
    .checksum     (checksum)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      lock_hist[fd_n[5:0]] <= locked;
      fd_n <= fd_n + 1;
    end
  end

  task automatic drive(input logic hs, input logic vs);
    @(negedge clk);
    vga.VGA_HS = hs;
    vga.VGA_VS = vs;
  endtask

  task automatic send_line(input int period, input int hsw, input logic vlow);
    for (int i = 0; i < period; i++) drive((i < hsw) ? 1'b0 : 1'b1, ~vlow);
  endtask

  task automatic send_frame(input int lines, input int period);
    for (int l = 0; l < lines; l++) send_line(period, HSW, l < VSW);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) drive(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    vga.VGA_HS = 1'b1;
    vga.VGA_VS = 1'b1;
    vga.VGA_R  = 4'h0;
    vga.VGA_G  = 4'h0;
    vga.VGA_B  = 4'h1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %0h want 0", locked); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %0h want 0", frame_done); end
    n_cmp++; if (h_period !== 12'd0) begin n_err++; $display("FAIL reset_h_period: got %0d want 0", h_period); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if ({err_h, err_v} !== 2'b00) begin n_err++; $display("FAIL reset_errs: got %b want 00", {err_h, err_v}); end
    n_cmp++; if (checksum !== 16'd0) begin n_err++; $display("FAIL reset_checksum: got %0d want 0", checksum); end
  endtask

  task automatic test_ideal();
    int base;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) drive(1'b1, 1'b1);
    base = fd_n;
    repeat (4) send_frame(VL, H);
    n_cmp++; if (fd_n - base !== 3) begin n_err++; $display("FAIL ideal_fd_count: got %0d want 3", fd_n - base); end
    n_cmp++; if (lock_hist[base + 1] !== 1'b0) begin n_err++; $display("FAIL ideal_lock_fd2: got %0h want 0", lock_hist[base + 1]); end
    n_cmp++; if (lock_hist[base + 2] !== 1'b1) begin n_err++; $display("FAIL ideal_lock_fd3: got %0h want 1", lock_hist[base + 2]); end
    n_cmp++; if (h_period !== 12'd40) begin n_err++; $display("FAIL ideal_h_period: got %0d want 40", h_period); end
    n_cmp++; if (hs_width !== 12'd8) begin n_err++; $display("FAIL ideal_hs_width: got %0d want 8", hs_width); end
    n_cmp++; if (v_lines !== 10'd20) begin n_err++; $display("FAIL ideal_v_lines: got %0d want 20", v_lines); end
    n_cmp++; if (vs_width !== 4'd2) begin n_err++; $display("FAIL ideal_vs_width: got %0d want 2", vs_width); end
    n_cmp++; if (frame_count !== 16'd3) begin n_err++; $display("FAIL ideal_frame_count: got %0d want 3", frame_count); end
    n_cmp++; if ({err_h, err_v} !== 2'b00) begin n_err++; $display("FAIL ideal_errs: got %b want 00", {err_h, err_v}); end
    n_cmp++; if (checksum !== CsumIdeal) begin n_err++; $display("FAIL ideal_checksum: got %0d want %0d", checksum, CsumIdeal); end
  endtask

  task automatic test_bad_hs_pulse();
    int base;
    base = fd_n;
    for (int l = 0; l < 5; l++) send_line(H, HSW, l < VSW);
    for (int i = 0; i < H; i++) begin
      drive((i < 3) ? 1'b0 : 1'b1, 1'b1);
      if (i == 2) begin
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL badpulse_locked_before: got %0h want 1", locked); end
      end
      if (i == 6) begin
        n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL badpulse_unlock: got %0h want 0", locked); end
        n_cmp++; if (err_h !== 1'b1) begin n_err++; $display("FAIL badpulse_err_h: got %0h want 1", err_h); end
        n_cmp++; if (hs_width !== 12'd3) begin n_err++; $display("FAIL badpulse_hs_width: got %0d want 3", hs_width); end
      end
    end
    for (int l = 6; l < VL; l++) send_line(H, HSW, 1'b0);
    repeat (4) send_frame(VL, H);
    n_cmp++; if (fd_n - base !== 4) begin n_err++; $display("FAIL relock_fd_count: got %0d want 4", fd_n - base); end
    n_cmp++; if (lock_hist[base + 2] !== 1'b0) begin n_err++; $display("FAIL relock_early: got %0h want 0", lock_hist[base + 2]); end
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL relock_locked: got %0h want 1", locked); end
    n_cmp++; if ({err_h, err_v} !== 2'b10) begin n_err++; $display("FAIL relock_errs: got %b want 10", {err_h, err_v}); end
  endtask

  task automatic test_short_frame();
    int base;
    base = fd_n;
    send_frame(VL - 1, H);
    send_frame(VL, H);
    n_cmp++; if (lock_hist[base] !== 1'b1) begin n_err++; $display("FAIL short_lock_prev: got %0h want 1", lock_hist[base]); end
    n_cmp++; if (lock_hist[base + 1] !== 1'b0) begin n_err++; $display("FAIL short_lock_fd: got %0h want 0", lock_hist[base + 1]); end
    n_cmp++; if (err_v !== 1'b1) begin n_err++; $display("FAIL short_err_v: got %0h want 1", err_v); end
    n_cmp++; if (v_lines !== 10'd19) begin n_err++; $display("FAIL short_v_lines: got %0d want 19", v_lines); end
  endtask

  task automatic test_rst_midframe();
    int base;
    for (int l = 0; l < 10; l++) send_line(H, HSW, l < VSW);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL midrst_locked: got %0h want 0", locked); end
    n_cmp++; if (frame_count !== 16'd0) begin n_err++; $display("FAIL midrst_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if ({err_h, err_v} !== 2'b00) begin n_err++; $display("FAIL midrst_errs: got %b want 00", {err_h, err_v}); end
    n_cmp++; if ({h_period, hs_width} !== 24'd0) begin n_err++; $display("FAIL midrst_h_meas: got %h want 0", {h_period, hs_width}); end
    n_cmp++; if ({v_lines, vs_width} !== 14'd0) begin n_err++; $display("FAIL midrst_v_meas: got %h want 0", {v_lines, vs_width}); end
    @(negedge clk);
    rst = 1'b0;
    for (int l = 10; l < VL; l++) send_line(H, HSW, 1'b0);
    base = fd_n;
    send_frame(VL, H);
    n_cmp++; if (fd_n - base !== 0) begin n_err++; $display("FAIL midrst_first_vs: got %0d want 0", fd_n - base); end
    send_frame(VL, H);
    n_cmp++; if (fd_n - base !== 1) begin n_err++; $display("FAIL midrst_second_vs: got %0d want 1", fd_n - base); end
    n_cmp++; if (frame_count !== 16'd1) begin n_err++; $display("FAIL midrst_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_tolerance();
    pulse_reset();
    repeat (5) send_frame(VL, H + 5);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL tol45_locked: got %0h want 0", locked); end
    n_cmp++; if (err_h !== 1'b0) begin n_err++; $display("FAIL tol45_err_h: got %0h want 0", err_h); end
    n_cmp++; if (h_period !== 12'd45) begin n_err++; $display("FAIL tol45_h_period: got %0d want 45", h_period); end
    pulse_reset();
    repeat (4) send_frame(VL, H + 3);
    n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL tol43_locked: got %0h want 1", locked); end
    n_cmp++; if (h_period !== 12'd43) begin n_err++; $display("FAIL tol43_h_period: got %0d want 43", h_period); end
  endtask

  task automatic test_missing_hs();
    repeat (4100) drive(1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b0) begin n_err++; $display("FAIL nohs_locked: got %0h want 0", locked); end
    n_cmp++; if ({err_h, err_v} !== 2'b10) begin n_err++; $display("FAIL nohs_errs: got %b want 10", {err_h, err_v}); end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_bad_hs_pulse();
    test_short_frame();
    test_rst_midframe();
    test_tolerance();
    test_missing_hs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
